// File: rtl/pfm.sv
// Multi-channel pulse former: per channel an optional input synchroniser, a selectable edge
// detector and a small IDLE/PULSE/HOLD FSM that emits a run-time-programmable pulse with an
// optional hold-off gap, retriggering and a sticky missed-edge flag.
module pfm #(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned EDGE   = 0,
  parameter int unsigned RETRIG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [W-1:0] len,
  input  logic [W-1:0] gap,
  input  logic         ovf_clr,
  output logic [N-1:0] q,
  output logic [N-1:0] busy,
  output logic [N-1:0] ovf
);

  typedef enum logic [1:0] {StIdle, StPulse, StHold} state_e;

  localparam bit Retrig = (RETRIG != 0);

  logic [N-1:0] s;
  logic [N-1:0] d_q;
  logic [N-1:0] edge_det;
  logic [N-1:0] drop;
  logic [N-1:0] ovf_q, ovf_d;
  logic [W-1:0] len_m1;
  logic [W-1:0] gap_m1;
  state_e       state_q [N];
  state_e       state_d [N];
  logic [W-1:0] cnt_q   [N];
  logic [W-1:0] cnt_d   [N];

  if (SYNC == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [N-1:0] sync_q [SYNC];

    // Synchroniser chain; reset to 0 so a level held across reset shows up as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= in;
        for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC-1];
  end

  // Previous synchronised level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= '0;
    else     d_q <= s;
  end

  // Edge selection.
  always_comb begin
    edge_det = '0;
    if (EDGE == 0)      edge_det = s & ~d_q;
    else if (EDGE == 1) edge_det = ~s & d_q;
    else                edge_det = s ^ d_q;
  end

  // A length of zero behaves as one cycle.
  assign len_m1 = (len == '0) ? '0 : len - W'(1);
  assign gap_m1 = gap - W'(1);

  // Per-channel next state, counter and dropped-edge detection.
  always_comb begin
    drop = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (edge_det[i]) begin
            state_d[i] = StPulse;
            cnt_d[i]   = len_m1;
          end
        end
        StPulse: begin
          if (edge_det[i] && Retrig) begin
            cnt_d[i] = len_m1;
          end else begin
            drop[i] = edge_det[i];
            if (cnt_q[i] == '0) begin
              if (gap != '0) begin
                state_d[i] = StHold;
                cnt_d[i]   = gap_m1;
              end else begin
                state_d[i] = StIdle;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - W'(1);
            end
          end
        end
        StHold: begin
          drop[i] = edge_det[i];
          if (cnt_q[i] == '0) state_d[i] = StIdle;
          else                cnt_d[i]   = cnt_q[i] - W'(1);
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Clear loses to a simultaneous set on the same channel.
  assign ovf_d = (ovf_q & ~{N{ovf_clr}}) | drop;

  // State, counter and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    q    = '0;
    busy = '0;
    for (int i = 0; i < N; i++) begin
      q[i]    = (state_q[i] == StPulse);
      busy[i] = (state_q[i] != StIdle);
    end
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_pfm.sv
// Scoreboard bench for pfm: three instances (rising/SYNC=2, both-edge retrigger/SYNC=0,
// falling/SYNC=3). Stimulus pushes expected pulses and status snapshots; a negedge monitor
// pops and compares whenever a pulse completes or a snapshot cycle arrives.
module tb_pfm;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_a, in_b, in_c;
  logic [W-1:0] len, gap;
  logic         ovf_clr;
  logic [N-1:0] q_a, busy_a, ovf_a;
  logic [N-1:0] q_b, busy_b, ovf_b;
  logic [N-1:0] q_c, busy_c, ovf_c;

  always #5 clk = ~clk;

  pfm #(.N(N), .W(W), .SYNC(2), .EDGE(0), .RETRIG(0)) u_a (
    .clk(clk), .rst(rst), .in(in_a), .len(len), .gap(gap), .ovf_clr(ovf_clr),
    .q(q_a), .busy(busy_a), .ovf(ovf_a)
  );
  pfm #(.N(N), .W(W), .SYNC(0), .EDGE(2), .RETRIG(1)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .len(len), .gap(gap), .ovf_clr(ovf_clr),
    .q(q_b), .busy(busy_b), .ovf(ovf_b)
  );
  pfm #(.N(N), .W(W), .SYNC(3), .EDGE(1), .RETRIG(0)) u_c (
    .clk(clk), .rst(rst), .in(in_c), .len(len), .gap(gap), .ovf_clr(ovf_clr),
    .q(q_c), .busy(busy_c), .ovf(ovf_c)
  );

  typedef struct {
    bit           is_stat;
    int           inst;
    int           ch;
    int           cyc;
    int           width;
    logic [N-1:0] q;
    logic [N-1:0] busy;
    logic [N-1:0] ovf;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] qv [3];
  logic [N-1:0] bv [3];
  logic [N-1:0] ov [3];
  bit           prev [3][N];
  int           st   [3][N];

  assign qv[0] = q_a;    assign qv[1] = q_b;    assign qv[2] = q_c;
  assign bv[0] = busy_a; assign bv[1] = busy_b; assign bv[2] = busy_c;
  assign ov[0] = ovf_a;  assign ov[1] = ovf_b;  assign ov[2] = ovf_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_pulse(input int inst, input int ch, input int start, input int width);
    exp_t e;
    e.is_stat = 1'b0; e.inst = inst; e.ch = ch; e.cyc = start; e.width = width;
    e.q = '0; e.busy = '0; e.ovf = '0;
    sb.push_back(e);
  endtask

  task automatic exp_stat(input int inst, input int cy, input logic [N-1:0] eq,
                          input logic [N-1:0] eb, input logic [N-1:0] eo);
    exp_t e;
    e.is_stat = 1'b1; e.inst = inst; e.ch = 0; e.cyc = cy; e.width = 0;
    e.q = eq; e.busy = eb; e.ovf = eo;
    sb.push_back(e);
  endtask

  task automatic check_pulse(input int inst, input int ch, input int start, input int width);
    int idx = -1;
    for (int k = 0; k < sb.size(); k++) begin
      if (!sb[k].is_stat && sb[k].inst == inst && sb[k].ch == ch) begin
        idx = k;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL pulse inst%0d ch%0d: got start=%0d width=%0d, required no pulse",
               inst, ch, start, width);
    end else begin
      if (start != sb[idx].cyc || width != sb[idx].width) begin
        errors++;
        $display("FAIL pulse inst%0d ch%0d: got start=%0d width=%0d, required start=%0d width=%0d",
                 inst, ch, start, width, sb[idx].cyc, sb[idx].width);
      end
      sb.delete(idx);
    end
  endtask

  // Monitor: completed pulses and due status snapshots.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst) begin
          prev[i][j] = 1'b0;
        end else if (qv[i][j] && !prev[i][j]) begin
          prev[i][j] = 1'b1;
          st[i][j]   = cyc;
        end else if (!qv[i][j] && prev[i][j]) begin
          prev[i][j] = 1'b0;
          check_pulse(i, j, st[i][j], cyc - st[i][j]);
        end
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].is_stat && sb[k].cyc == cyc) begin
        checks++;
        if (qv[sb[k].inst] !== sb[k].q || bv[sb[k].inst] !== sb[k].busy ||
            ov[sb[k].inst] !== sb[k].ovf) begin
          errors++;
          $display("FAIL status inst%0d cyc%0d: got q/busy/ovf=%b/%b/%b, required %b/%b/%b",
                   sb[k].inst, cyc, qv[sb[k].inst], bv[sb[k].inst], ov[sb[k].inst],
                   sb[k].q, sb[k].busy, sb[k].ovf);
        end
        sb.delete(k);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; in_a = '0; in_b = '0; in_c = '0;
    len = 4'd5; gap = '0; ovf_clr = 1'b0;

    // Reset state.
    step(2);
    c = cyc;
    for (int i = 0; i < 3; i++) exp_stat(i, c + 1, '0, '0, '0);
    step(3);
    rst = 1'b0;
    step(3);

    // Rising edge, len=5, long input high: one 5-cycle pulse, latency SYNC.
    len = 4'd5; gap = '0;
    c = cyc;
    in_a[0] = 1'b1;
    exp_pulse(0, 0, c + 3, 5);
    exp_stat(0, c + 3, 4'b0001, 4'b0001, '0);
    exp_stat(0, c + 8, '0, '0, '0);
    step(20);
    in_a[0] = 1'b0;
    step(6);

    // Both edges, len=1, SYNC=0: one pulse per toggle.
    len = 4'd1;
    for (int t = 0; t < 4; t++) begin
      c = cyc;
      in_b[1] = ~in_b[1];
      exp_pulse(1, 1, c + 1, 1);
      step(10);
    end

    // No retrigger, len=8, gap=4: edges in PULSE and HOLD dropped, ovf set and cleared.
    len = 4'd8; gap = 4'd4;
    c = cyc;
    in_a[2] = 1'b1;
    exp_pulse(0, 2, c + 3, 8);
    step(1); in_a[2] = 1'b0;
    step(2); in_a[2] = 1'b1;                       // c+3
    step(2); in_a[2] = 1'b0;                       // c+5
    exp_stat(0, c + 7, 4'b0100, 4'b0100, 4'b0100);
    step(3); ovf_clr = 1'b1;                       // c+8
    step(1); ovf_clr = 1'b0;                       // c+9
    exp_stat(0, c + 9, 4'b0100, 4'b0100, '0);
    step(1); in_a[2] = 1'b1;                       // c+10, lands in HOLD
    exp_stat(0, c + 12, '0, 4'b0100, '0);
    exp_stat(0, c + 13, '0, 4'b0100, 4'b0100);
    exp_stat(0, c + 15, '0, '0, 4'b0100);
    step(2); in_a[2] = 1'b0;                       // c+12
    step(4); ovf_clr = 1'b1;                       // c+16
    step(1); ovf_clr = 1'b0;                       // c+17
    exp_stat(0, c + 17, '0, '0, '0);
    step(3); in_a[2] = 1'b1;                       // c+20, after HOLD
    exp_pulse(0, 2, c + 23, 8);
    step(2); in_a[2] = 1'b0;
    step(20);

    // Retrigger, len=6: edges at 0 and 4 give one 10-cycle pulse, no ovf.
    len = 4'd6; gap = '0;
    c = cyc;
    in_b[0] = 1'b1;
    exp_pulse(1, 0, c + 1, 10);
    exp_stat(1, c + 6, 4'b0001, 4'b0001, '0);
    exp_stat(1, c + 11, '0, '0, '0);
    step(4); in_b[0] = 1'b0;
    step(15);

    // len=0, gap=0: edges two cycles apart give two 1-cycle pulses.
    len = '0; gap = '0;
    c = cyc;
    in_a[1] = 1'b1;
    exp_pulse(0, 1, c + 3, 1);
    exp_pulse(0, 1, c + 5, 1);
    exp_stat(0, c + 7, '0, '0, '0);
    step(1); in_a[1] = 1'b0;
    step(1); in_a[1] = 1'b1;
    step(1); in_a[1] = 1'b0;
    step(8);

    // Maximum length 2^W-1.
    len = 4'd15;
    c = cyc;
    in_a[3] = 1'b1;
    exp_pulse(0, 3, c + 3, 15);
    step(2); in_a[3] = 1'b0;
    step(20);

    // Falling edge with SYNC=3.
    len = 4'd3;
    in_c[1] = 1'b1;
    step(5);
    c = cyc;
    in_c[1] = 1'b0;
    exp_pulse(2, 1, c + 4, 3);
    step(10);

    // Reset mid-pulse with ovf set; inputs held high across release.
    len = 4'd8; gap = '0;
    c = cyc;
    in_a[0] = 1'b1; in_c[0] = 1'b1;
    step(1); in_a[0] = 1'b0;
    step(1); in_a[0] = 1'b1;                       // c+2, dropped in PULSE
    exp_stat(0, c + 6, 4'b0001, 4'b0001, 4'b0001);
    step(5);                                       // c+7
    #1 rst = 1'b1;
    exp_stat(0, c + 7, '0, '0, '0);
    exp_stat(2, c + 7, '0, '0, '0);
    step(3);
    rst = 1'b0;
    c = cyc;
    exp_pulse(0, 0, c + 3, 8);
    step(25);

    // Anything still queued never appeared.
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing inst%0d ch%0d cyc%0d: got nothing, required %s",
               sb[0].inst, sb[0].ch, sb[0].cyc, sb[0].is_stat ? "status" : "pulse");
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pfm.md
# pfm

Multi-channel, parametrised pulse former, replacing single-channel fixed-width pulse formers wherever several strobes are needed. Each of N independent channels optionally synchronises its asynchronous input, detects a selectable edge, and emits a pulse whose width is set at run time. Optional retriggering, a programmable hold-off gap after each pulse, and a sticky missed-edge flag per channel are provided. It sits between raw board or cross-domain signals and the control logic that consumes single-clock strobes.

## Interface
- N, 4: number of channels, 1..32
- W, 8: width of length/gap counters, 2..16
- SYNC, 2: synchroniser flops per input, 0 (input already in clk domain) or 2..3
- EDGE, 0: 0 = rising, 1 = falling, 2 = both edges
- RETRIG, 0: 1 = edge during pulse restarts the pulse length
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in  in  N  per-channel trigger inputs
- len  in  W  pulse width in clk cycles; 0 treated as 1
- gap  in  W  hold-off cycles after pulse end; 0 = none
- ovf_clr  in  1  clears all ovf bits
- q  out  N  output pulses
- busy  out  N  channel not idle (PULSE or HOLD)
- ovf  out  N  sticky: an edge was dropped

## Operation
- Per channel: in → SYNC-flop chain → s; d <= s; edge = s&~d (EDGE=0), ~s&d (EDGE=1), s^d (EDGE=2).
- Per-channel FSM, states IDLE, PULSE, HOLD; one W-bit counter per channel; len and gap shared but latched per channel.
- IDLE: on edge → PULSE, counter loads max(len,1)−1, q set.
- PULSE: q high; counter decrements; at 0 → HOLD with counter = gap−1 if gap≠0, else → IDLE; q clears.
- HOLD: q low; counter decrements; at 0 → IDLE.
- Edge in PULSE: RETRIG=1 → counter reloads max(len,1)−1, pulse extends, no ovf; RETRIG=0 → ignored, ovf set.
- Edge in HOLD (including its final cycle) → ignored, ovf set.
- Edge in the last PULSE cycle counts as in PULSE.
- len and gap are sampled only on load; later changes affect the next load.
- busy = (state≠IDLE).
- ovf_clr clears every ovf bit; a simultaneous set on a channel wins.
- Channels are fully independent; simultaneous edges on several channels are all served.

## Timing
- Reset: asynchronous assertion forces all sync flops, d, state=IDLE, counters=0, q=0, busy=0, ovf=0 immediately, including mid-pulse. Release is synchronous to clk.
- Input held high across reset release yields one rising edge after release. That edge fires a pulse for EDGE=0/2; none for EDGE=1.
- Latency: in first sampled at the new level on clk edge k → q high after edge k+SYNC. For SYNC=0, q is high after edge k.
- Pulse width: exactly max(len,1) cycles, or longer on retrigger: the pulse ends max(len,1) cycles after the last accepted edge.
- Minimum q low time between pulses: gap+1 cycles. With gap=0, an edge detected the cycle after q falls is accepted.
- busy rises with q and falls the cycle the FSM enters IDLE.
- ovf rises one cycle after the dropped edge is detected.

## Test plan
- N=4, SYNC=2, EDGE=0, len=5, gap=0: 20-cycle high on in[0] → q[0] high 5 cycles, starting 2 cycles after first sample. Other q bits stay 0; busy[0] high 5 cycles.
- EDGE=2, len=1: in[1] toggles every 10 cycles → one 1-cycle q[1] pulse per toggle, 10 cycles apart.
- RETRIG=0, len=8, gap=4: second edge 3 cycles after the first, third edge inside HOLD → single 8-cycle pulse. ovf[2] set, cleared by an ovf_clr pulse. Next edge after HOLD is accepted.
- RETRIG=1, len=6: edges at cycle 0 and cycle 4 → one continuous pulse of 10 cycles, ovf stays 0.
- len=0, gap=0: edges 2 cycles apart → 1-cycle pulses each, 1-cycle low between them. len=2^W−1 gives a pulse of 2^W−1 cycles.
- rst asserted mid-pulse, between clk edges → q, busy, ovf drop to 0 at once. in held high at release → one pulse for EDGE=0, none for EDGE=1.
